// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset vector and FSM state type for the
// instruction-fetch front end (no ports; imported by all fetch files).
package inst_fetch_pkg;

  localparam int WORD = 64;
  localparam int INST_SIZE = 32;
  localparam int INST_BYTES = 4;
  localparam int FETCH_DEPTH = 2;
  localparam logic [WORD-1:0] DEF_RESET_PC = 64'h0;

  typedef enum logic {
    ST_RUN,
    ST_KILL
  } fetch_st_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus: imem request/response plus the inst valid/ready stream and
// redirect. master = fetch unit, slave = memory/decode environment.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int PC_W = WORD,
  parameter int INST_W = INST_SIZE
) ();

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              id_ready;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;

  modport master (
    output imem_req, imem_addr,
    output inst_valid, inst, inst_pc,
    input  imem_rdata, id_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    input  inst_valid, inst, inst_pc,
    output imem_rdata, id_ready,
    output redirect, redirect_pc
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, inst}. Ports: clk, rst, push,
// pop, flush (beats push), wdata in; count and registered head out.
module inst_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 96
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d = bump(wr_q);
      end
      if (pop) begin
        rd_d = bump(rd_q);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch.sv
// LEGv8 fetch front end: pc, 1-cycle imem issue, kill FSM, output FIFO.
// Ports: clk, rst (sync, active-high), bus (inst_fetch_if.master).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              PC_W     = WORD,
  parameter int              INST_W   = INST_SIZE,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              DEPTH    = FETCH_DEPTH
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = PC_W + INST_W;

  fetch_st_e       st_q, st_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic [CW:0]     occ;
  logic            pop;
  logic            push;
  logic            issue;

  assign pop = bus.inst_valid & bus.id_ready;

  // Slots already claimed once this cycle's pop leaves the FIFO.
  assign occ = (CW+1)'(count)
             + (CW+1)'(inflight_q)
             - (CW+1)'(pop);

  assign issue = !rst && !bus.redirect
              && (occ < (CW+1)'(DEPTH));

  assign push = inflight_q && (st_q == ST_RUN);

  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.redirect) begin
      pc_d = {bus.redirect_pc[PC_W-1:2], 2'b00};
    end else if (issue) begin
      pc_d     = pc_q + PC_W'(INST_BYTES);
      req_pc_d = pc_q;
    end
    unique case (st_q)
      ST_RUN: begin
        if (bus.redirect && inflight_q) begin
          st_d = ST_KILL;
        end
      end
      ST_KILL: begin
        st_d = (bus.redirect && inflight_q)
             ? ST_KILL : ST_RUN;
      end
      default: st_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_RUN;
      pc_q       <= {RESET_PC[PC_W-1:2], 2'b00};
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  inst_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata ({req_pc_q, bus.imem_rdata}),
    .count (count),
    .head  (head)
  );

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_pc    = head[EW-1:INST_W];
  assign bus.inst       = head[INST_W-1:0];

endmodule
